// File: rtl/pe_sys_v2.sv
// pe_sys_v2: systolic-array processing element with weight-stationary (WS)
// and output-stationary (OS) modes.
//
// WS mode:
//   - Weights are loaded row-indexed: the first T = ROWS-1-ROW_IDX beats are
//     passed south, the next beat is captured into the shadow register, and
//     any later beats are dropped.
//   - switch_in copies the shadow weight into the active weight.
// OS mode:
//   - The PE accumulates act*weight_in locally and emits the result on drain.
//
// Optional feature: define PE_OVF_FLAG_EN to add the ovf_sticky output.
module pe_sys_v2 #(
    parameter int DATA_W  = 16,
    parameter int FRAC_W  = 8,
    parameter int PSUM_W  = 32,
    parameter int ROWS    = 16,
    parameter int ROW_IDX = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              clr,
    input  logic              mode_os,
    input  logic [DATA_W-1:0] act_in,
    input  logic              act_vld_in,
    input  logic              switch_in,
    input  logic              drain_in,
    input  logic [DATA_W-1:0] weight_in,
    input  logic              weight_vld_in,
    input  logic [PSUM_W-1:0] psum_in,
    output logic [DATA_W-1:0] act_out,
    output logic              act_vld_out,
    output logic              switch_out,
    output logic              drain_out,
    output logic [DATA_W-1:0] weight_out,
    output logic              weight_vld_out,
    output logic [PSUM_W-1:0] psum_out
`ifdef PE_OVF_FLAG_EN
    ,
    output logic              ovf_sticky
`endif
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int RND_W  = PROD_W + 1;
    localparam int SCL_W  = RND_W - FRAC_W;
    // The sum is one bit wider than either operand, so it can never wrap
    // before the saturation check sees it.
    localparam int SUM_W  = ((PSUM_W > SCL_W) ? PSUM_W : SCL_W) + 1;
    localparam int T      = ROWS - 1 - ROW_IDX;
    localparam int CNT_W  = $clog2(ROWS + 1);

    localparam logic signed [RND_W-1:0] HALF   = RND_W'(1) << (FRAC_W - 1);
    localparam logic [PSUM_W-1:0]       SAT_HI = {1'b0, {(PSUM_W-1){1'b1}}};
    localparam logic [PSUM_W-1:0]       SAT_LO = {1'b1, {(PSUM_W-1){1'b0}}};

    logic signed [DATA_W-1:0] w_act;
    logic signed [DATA_W-1:0] w_sh;
    logic signed [PSUM_W-1:0] acc;
    logic [CNT_W-1:0]         cnt;

    logic signed [DATA_W-1:0] b_op;
    logic signed [PSUM_W-1:0] base;
    logic signed [PROD_W-1:0] prod;
    logic signed [RND_W-1:0]  rnd;
    logic signed [SCL_W-1:0]  scaled;
    logic signed [SUM_W-1:0]  addend;
    logic signed [SUM_W-1:0]  sum;
    logic [SUM_W-PSUM_W:0]    top;
    logic                     mac_vld;
    logic                     clamp;
    logic                     clamp_hit;
    logic [PSUM_W-1:0]        sat;

    // One shared MAC datapath.
    //   - WS mode: adds to psum_in, using the active weight.
    //   - OS mode: adds to the local accumulator, using weight_in.
    always_comb begin
        mac_vld = act_vld_in & weight_vld_in;
        b_op    = mode_os ? $signed(weight_in) : w_act;
        base    = mode_os ? acc : $signed(psum_in);
        prod    = PROD_W'($signed(act_in)) * PROD_W'(b_op);
        rnd     = RND_W'(prod) + HALF;
        scaled  = SCL_W'(rnd >>> FRAC_W);
        addend  = (mode_os ? mac_vld : 1'b1) ? SUM_W'(scaled) : '0;
        sum     = SUM_W'(base) + addend;
        top     = sum[SUM_W-1:PSUM_W-1];
        clamp   = !((&top) || !(|top));
        sat     = clamp ? (sum[SUM_W-1] ? SAT_LO : SAT_HI) : sum[PSUM_W-1:0];
        clamp_hit = clamp & (mode_os ? mac_vld : act_vld_in);
    end

    // Eastward forwarding of the activation and the control strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            act_out     <= '0;
            act_vld_out <= 1'b0;
            switch_out  <= 1'b0;
            drain_out   <= 1'b0;
        end else if (en) begin
            if (act_vld_in) act_out <= act_in;
            act_vld_out <= act_vld_in;
            switch_out  <= switch_in;
            drain_out   <= drain_in;
        end
    end

    // Weight path.
    //   - WS mode: row-indexed load, plus switch from shadow to active.
    //   - OS mode: weight_in is passed south unconditionally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_act          <= '0;
            w_sh           <= '0;
            cnt            <= '0;
            weight_out     <= '0;
            weight_vld_out <= 1'b0;
        end else if (en) begin
            weight_out     <= '0;
            weight_vld_out <= 1'b0;
            if (mode_os) begin
                if (weight_vld_in) begin
                    weight_out     <= weight_in;
                    weight_vld_out <= 1'b1;
                end
            end else begin
                if (weight_vld_in) begin
                    if (cnt < CNT_W'(T)) begin
                        weight_out     <= weight_in;
                        weight_vld_out <= 1'b1;
                        cnt            <= cnt + 1'b1;
                    end else if (cnt == CNT_W'(T)) begin
                        w_sh <= $signed(weight_in);
                        cnt  <= CNT_W'(T + 1);
                    end
                end
                // On a same-cycle capture, active takes the old shadow.
                if (switch_in) begin
                    w_act <= w_sh;
                    cnt   <= '0;
                end
            end
            if (clr) cnt <= '0;
        end
    end

    // Psum output and OS accumulator.
    //   - A drain emits the accumulator, including this cycle's beat.
    //   - Otherwise psum_in is passed straight through.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            psum_out <= '0;
            acc      <= '0;
        end else if (en) begin
            if (mode_os) begin
                if (drain_in) begin
                    psum_out <= sat;
                    acc      <= '0;
                end else begin
                    psum_out <= psum_in;
                    if (mac_vld) acc <= $signed(sat);
                end
            end else begin
                psum_out <= act_vld_in ? sat : '0;
            end
            if (clr) acc <= '0;
        end
    end

`ifdef PE_OVF_FLAG_EN
    // Sticky record of any saturating result; clr wins over a same-cycle set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      ovf_sticky <= 1'b0;
        else if (en)  ovf_sticky <= clr ? 1'b0 : (ovf_sticky | clamp_hit);
    end
`else
    logic unused_clamp;
    assign unused_clamp = clamp_hit;
`endif

endmodule

// File: tb/tb_pe_sys_v2.sv
// Testbench for pe_sys_v2: directed vectors, an integer-level reference
// model checked every cycle, and hand-computed literal checks.
module tb_pe_sys_v2;
    localparam int DW = 16;
    localparam int FW = 8;
    localparam int PW = 16;
    localparam int RW = 4;
    localparam int RI = 1;
    localparam int T  = RW - 1 - RI;
    localparam longint PMAX = (longint'(1) << (PW - 1)) - 1;
    localparam longint PMIN = -(longint'(1) << (PW - 1));

    logic          clk = 1'b0;
    logic          rst, en, clr, mode_os;
    logic [DW-1:0] act_in, weight_in;
    logic          act_vld_in, switch_in, drain_in, weight_vld_in;
    logic [PW-1:0] psum_in;
    logic [DW-1:0] act_out, weight_out;
    logic          act_vld_out, switch_out, drain_out, weight_vld_out;
    logic [PW-1:0] psum_out;
`ifdef PE_OVF_FLAG_EN
    logic          ovf_sticky;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    pe_sys_v2 #(.DATA_W(DW), .FRAC_W(FW), .PSUM_W(PW), .ROWS(RW), .ROW_IDX(RI)) dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .mode_os(mode_os),
        .act_in(act_in), .act_vld_in(act_vld_in), .switch_in(switch_in),
        .drain_in(drain_in), .weight_in(weight_in), .weight_vld_in(weight_vld_in),
        .psum_in(psum_in), .act_out(act_out), .act_vld_out(act_vld_out),
        .switch_out(switch_out), .drain_out(drain_out), .weight_out(weight_out),
        .weight_vld_out(weight_vld_out), .psum_out(psum_out)
`ifdef PE_OVF_FLAG_EN
        , .ovf_sticky(ovf_sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model, in plain integer arithmetic.
    logic [DW-1:0] m_act_out = '0, m_w_out = '0;
    logic          m_act_vld = 1'b0, m_sw = 1'b0, m_dr = 1'b0, m_wv = 1'b0, m_ovf = 1'b0;
    logic [PW-1:0] m_psum = '0;
    logic [DW-1:0] m_w_act = '0, m_w_sh = '0;
    longint        m_acc = 0;
    int            m_beats = 0;

    function automatic longint scaled_f(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return (p + (longint'(1) << (FW - 1))) >>> FW;
    endfunction

    function automatic longint sat_f(input longint s, output bit c);
        c = (s > PMAX) || (s < PMIN);
        return (s > PMAX) ? PMAX : ((s < PMIN) ? PMIN : s);
    endfunction

    always @(posedge clk) begin
        longint s, r;
        bit c, ovf_set, mac;
        logic [DW-1:0] nsh, nact;
        if (rst) begin
            m_act_out = '0; m_w_out = '0; m_act_vld = 0; m_sw = 0; m_dr = 0; m_wv = 0;
            m_ovf = 0; m_psum = '0; m_w_act = '0; m_w_sh = '0; m_acc = 0; m_beats = 0;
        end else if (en) begin
            ovf_set = 0;
            if (!mode_os) begin
                if (act_vld_in) begin
                    s = longint'($signed(psum_in)) + scaled_f(act_in, m_w_act);
                    r = sat_f(s, c);
                    ovf_set = c;
                    m_psum = r[PW-1:0];
                end else m_psum = '0;
                m_wv = 0; m_w_out = '0; nsh = m_w_sh; nact = m_w_act;
                if (weight_vld_in) begin
                    if (m_beats < T) begin
                        m_w_out = weight_in; m_wv = 1; m_beats++;
                    end else if (m_beats == T) begin
                        nsh = weight_in; m_beats = T + 1;
                    end
                end
                if (switch_in) begin nact = m_w_sh; m_beats = 0; end
                m_w_sh = nsh; m_w_act = nact;
            end else begin
                m_wv = weight_vld_in;
                m_w_out = weight_vld_in ? weight_in : '0;
                mac = act_vld_in && weight_vld_in;
                s = m_acc + (mac ? scaled_f(act_in, weight_in) : 0);
                r = sat_f(s, c);
                ovf_set = mac && c;
                if (drain_in) begin m_psum = r[PW-1:0]; m_acc = 0; end
                else begin m_psum = psum_in; if (mac) m_acc = r; end
            end
            if (clr) begin m_acc = 0; m_beats = 0; m_ovf = 0; end
            else m_ovf = m_ovf | ovf_set;
            if (act_vld_in) m_act_out = act_in;
            m_act_vld = act_vld_in; m_sw = switch_in; m_dr = drain_in;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("psum_out", psum_out, m_psum);
        chk("act_out", act_out, m_act_out);
        chk("act_vld_out", act_vld_out, m_act_vld);
        chk("switch_out", switch_out, m_sw);
        chk("drain_out", drain_out, m_dr);
        chk("weight_out", weight_out, m_w_out);
        chk("weight_vld_out", weight_vld_out, m_wv);
`ifdef PE_OVF_FLAG_EN
        chk("ovf_sticky", ovf_sticky, m_ovf);
`endif
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        en = 1; clr = 0; act_vld_in = 0; weight_vld_in = 0; switch_in = 0; drain_in = 0;
    endtask

    task automatic beat(input logic [DW-1:0] w);
        idle(); weight_in = w; weight_vld_in = 1; step();
    endtask

    task automatic sw();
        idle(); switch_in = 1; step();
    endtask

    task automatic ws_mac(input logic [DW-1:0] a, input logic [PW-1:0] p);
        idle(); act_in = a; act_vld_in = 1; psum_in = p; step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; mode_os = 0; act_in = '0; weight_in = '0; psum_in = '0; idle();
        step(); step();
        chk("reset psum_out", psum_out, 0);
        chk("reset act_out", act_out, 0);
        chk("reset weight_vld_out", weight_vld_out, 0);
        rst = 0;

        // Row-indexed load with T=2.
        beat(16'h0011); chk("load fwd0", {weight_vld_out, weight_out}, {1'b1, 16'h0011});
        beat(16'h0022); chk("load fwd1", {weight_vld_out, weight_out}, {1'b1, 16'h0022});
        beat(16'h0033); chk("load capture", {weight_vld_out, weight_out}, 0);
        beat(16'h0044); chk("load drop", {weight_vld_out, weight_out}, 0);
        sw();           chk("switch_out", switch_out, 1);
        ws_mac(16'h0100, 16'h0000); chk("active 0x33", psum_out, 16'h0033);

        // WS basic.
        beat(16'h00AA); beat(16'h00BB); beat(16'h0180); sw();
        ws_mac(16'h0200, 16'h0100);
        chk("ws basic psum", psum_out, 16'h0400);
        chk("ws basic act_out", act_out, 16'h0200);
        chk("ws basic act_vld", act_vld_out, 1);

        // Capture and switch in the same cycle.
        beat(16'h0001); beat(16'h0002);
        idle(); weight_in = 16'h0080; weight_vld_in = 1; switch_in = 1; step();
        ws_mac(16'h0100, 16'h0000); chk("cap+switch old shadow", psum_out, 16'h0180);
        sw();

        // Rounding with weight 0.5.
        ws_mac(16'h0001, 16'h0000); chk("round up", psum_out, 16'h0001);
        ws_mac(16'hFFFF, 16'h0000); chk("round to 0", psum_out, 16'h0000);
        idle(); psum_in = 16'h1234; step(); chk("ws no valid", psum_out, 0);

        // Saturation with weight 1.0.
        beat(16'h0005); beat(16'h0006); beat(16'h0100); sw();
        ws_mac(16'h0300, 16'h7F00); chk("sat high", psum_out, 16'h7FFF);
`ifdef PE_OVF_FLAG_EN
        chk("ovf set", ovf_sticky, 1);
`endif
        ws_mac(16'hFD00, 16'h8100); chk("sat low", psum_out, 16'h8000);
        idle(); clr = 1; step();
`ifdef PE_OVF_FLAG_EN
        chk("ovf clr", ovf_sticky, 0);
`endif

        // Hold: inputs keep changing while en=0.
        ws_mac(16'h0100, 16'h0010); chk("pre-hold psum", psum_out, 16'h0110);
        for (int i = 0; i < 5; i++) begin
            en = 0; act_in = 16'h0200 + 16'(i); act_vld_in = 1; psum_in = 16'h0020;
            weight_in = 16'h0F00; weight_vld_in = 1; switch_in = 1; drain_in = 1;
            step();
            chk("hold psum", psum_out, 16'h0110);
            chk("hold act", act_out, 16'h0100);
        end

        // OS mode: accumulate and drain.
        idle(); mode_os = 1; clr = 1; psum_in = '0; step();
        for (int i = 0; i < 3; i++) begin
            idle(); act_in = 16'h0100; act_vld_in = 1; weight_in = 16'h0200; weight_vld_in = 1; step();
            chk("os fwd", {weight_vld_out, weight_out}, {1'b1, 16'h0200});
        end
        idle(); drain_in = 1; step();
        chk("os drain", psum_out, 16'h0600);
        chk("os drain_out", drain_out, 1);
        idle(); drain_in = 1; step(); chk("os drained", psum_out, 0);
        idle(); psum_in = 16'h0055; step(); chk("os chain", psum_out, 16'h0055);
        idle(); act_in = 16'h0100; act_vld_in = 1; weight_in = 16'h0200; weight_vld_in = 1; step();
        idle(); act_in = 16'h0100; act_vld_in = 1; weight_in = 16'h0200; weight_vld_in = 1; drain_in = 1; step();
        chk("os drain+mac", psum_out, 16'h0400);

        // Back to WS; the active weight survived the OS phase.
        idle(); mode_os = 0; step();
        ws_mac(16'h0100, 16'h0010); chk("mode retain", psum_out, 16'h0110);

        // Reset in the middle of a load.
        beat(16'h0077); beat(16'h0088); beat(16'h0099);
        idle(); rst = 1; step();
        chk("rst psum", psum_out, 0);
        chk("rst act", {act_vld_out, act_out}, 0);
        chk("rst weight", {weight_vld_out, weight_out}, 0);
        rst = 0; sw();
        ws_mac(16'h0100, 16'h0010); chk("rst active 0", psum_out, 16'h0010);

        idle(); step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
